// File: rtl/fu_pkg.sv
// -----------------------------------------------------------------------------
// fu_pkg
//   Definitions shared by the execute-stage functional units (multiply, divide).
//   - fu_state_e      : common three-state FU sequencer encoding
//   - FU_DIV_LATENCY  : cycles from the EN cycle to the finish cycle at the
//                       default width; fu_div_latency() for other widths
//   - FU_FINISH_CYCLES: width of the finish pulse, identical for every FU
// -----------------------------------------------------------------------------
package fu_pkg;

    typedef enum logic [1:0] {
        FU_IDLE = 2'b00,
        FU_CALC = 2'b01,
        FU_DONE = 2'b10
    } fu_state_e;

    localparam int FU_DIV_WIDTH     = 32;
    localparam int FU_DIV_LATENCY   = FU_DIV_WIDTH + 1;
    localparam int FU_FINISH_CYCLES = 1;

    // One quotient bit per CALC cycle plus the DONE cycle.
    function automatic int fu_div_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/fu_div_if.sv
// -----------------------------------------------------------------------------
// fu_div_if
//   Issue-side handshake of the divide functional unit.
//   EN, A, B      : start request and operands (driven by the issue logic)
//   res, rem      : registered quotient and remainder (driven by the FU)
//   finish        : one-cycle pulse, res/rem valid for the new operation
//   busy          : FU is in CALC or DONE; EN is ignored while high
//   Modports: master = issue logic, slave = functional unit.
// -----------------------------------------------------------------------------
interface fu_div_if #(
    parameter int WIDTH = 32
);
    import fu_pkg::*;

    logic             EN;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rem;
    logic             finish;
    logic             busy;

    modport master (
        output EN, A, B,
        input  res, rem, finish, busy
    );

    modport slave (
        input  EN, A, B,
        output res, rem, finish, busy
    );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring division iteration.
//   Ports:
//     prem      in   WIDTH  partial remainder (always < divisor on entry)
//     quot      in   WIDTH  quotient register, dividend bits still in the MSBs
//     divisor   in   WIDTH  divisor magnitude
//     prem_next out  WIDTH  partial remainder after this iteration
//     quot_next out  WIDTH  quotient register after this iteration
// -----------------------------------------------------------------------------
module div_step
    import fu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // Because prem < divisor, shifted < 2*divisor and the difference lies in
    // (-2^WIDTH, 2^WIDTH): WIDTH+1 bits hold it, bit WIDTH is its sign.
    always_comb begin
        shifted   = {prem, quot[WIDTH-1]};
        trial     = shifted - {1'b0, divisor};
        fits      = ~trial[WIDTH];
        prem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_next = {quot[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/fu_div.sv
// -----------------------------------------------------------------------------
// fu_div
//   Multi-cycle integer divide functional unit. Radix-2 restoring divider,
//   one quotient bit per cycle, fixed latency: finish pulses WIDTH+1 cycles
//   after the cycle in which EN is sampled in IDLE.
//   Ports:
//     clk   in  single clock, rising edge
//     rst   in  synchronous, active-high reset; aborts an operation in flight
//     bus   slave side of fu_div_if (EN, A, B in; res, rem, finish, busy out)
//   Divide by zero: res = all ones, rem = A.
//   Build option FU_DIV_SIGNED_EN: two's-complement operands, truncating
//   division (quotient negated when signs differ, remainder follows the
//   dividend's sign); A = -2^(WIDTH-1), B = -1 gives res = A, rem = 0.
//   Without the macro the unit is unsigned and carries no sign logic.
// -----------------------------------------------------------------------------
module fu_div
    import fu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    fu_div_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LAST_ITER = cnt_t'(WIDTH - 1);

    fu_state_e        state, state_next;
    cnt_t             cnt;
    logic             load, calc, last;

    // Datapath state
    logic [WIDTH-1:0] prem, quot, divisor;
    logic [WIDTH-1:0] a_reg;
    logic             div_zero;
    logic [WIDTH-1:0] prem_next, quot_next;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic [WIDTH-1:0] res_q, rem_q;

`ifdef FU_DIV_SIGNED_EN
    logic             neg_q, neg_r, ovf;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        calc       = 1'b0;
        last       = (cnt == LAST_ITER);
        unique case (state)
            FU_IDLE: begin
                if (bus.EN) begin
                    load       = 1'b1;
                    state_next = FU_CALC;
                end
            end
            FU_CALC: begin
                calc = 1'b1;
                if (last) begin
                    state_next = FU_DONE;
                end
            end
            FU_DONE: begin
                state_next = FU_IDLE;
            end
            default: begin
                state_next = FU_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FU_IDLE;
            cnt   <= '0;
            res_q <= '0;
            rem_q <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                cnt <= '0;
            end else if (calc && !last) begin
                cnt <= cnt + cnt_t'(1);
            end
            if (calc && last) begin
                res_q <= q_fin;
                rem_q <= r_fin;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand preparation: the core always divides magnitudes
    // ------------------------------------------------------------------
    always_comb begin
`ifdef FU_DIV_SIGNED_EN
        a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
`else
        a_mag = bus.A;
        b_mag = bus.B;
`endif
    end

    // NOTE: datapath registers have no reset; they are fully loaded on every
    // start and only observed after the FSM has walked through CALC.
    always_ff @(posedge clk) begin
        if (load) begin
            prem     <= '0;
            quot     <= a_mag;
            divisor  <= b_mag;
            a_reg    <= bus.A;
            div_zero <= (bus.B == '0);
`ifdef FU_DIV_SIGNED_EN
            neg_q    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            neg_r    <= bus.A[WIDTH-1];
            ovf      <= (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
`endif
        end else if (calc) begin
            prem <= prem_next;
            quot <= quot_next;
        end
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem      (prem),
        .quot      (quot),
        .divisor   (divisor),
        .prem_next (prem_next),
        .quot_next (quot_next)
    );

    // ------------------------------------------------------------------
    // Final result: built from the last iteration's outputs so res/rem
    // are written once, on the edge that leaves CALC.
    // ------------------------------------------------------------------
    always_comb begin
        q_fin = quot_next;
        r_fin = prem_next;
`ifdef FU_DIV_SIGNED_EN
        if (neg_q) begin
            q_fin = -quot_next;
        end
        if (neg_r) begin
            r_fin = -prem_next;
        end
        // The magnitude path already yields this, but the override keeps
        // the architectural result independent of the core's corner case.
        if (ovf) begin
            q_fin = a_reg;
            r_fin = '0;
        end
`endif
        // Zero divisor overrides everything, including sign correction.
        if (div_zero) begin
            q_fin = '1;
            r_fin = a_reg;
        end
    end

    assign bus.res    = res_q;
    assign bus.rem    = rem_q;
    assign bus.finish = (state == FU_DONE);
    assign bus.busy   = (state != FU_IDLE);

endmodule

// File: tb/tb_fu_div.sv
// -----------------------------------------------------------------------------
// tb_fu_div
//   Self-checking bench for fu_div. Each started operation pushes its expected
//   quotient, remainder and start cycle onto a scoreboard; a monitor pops and
//   compares on every finish pulse. Build with +define+FU_DIV_SIGNED_EN to
//   exercise the signed configuration.
// -----------------------------------------------------------------------------
module tb_fu_div;
    import fu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        int           start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_finish = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    fu_div_if #(.WIDTH(W)) bus ();

    fu_div #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Reference model: language division with the unit's special cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
`ifdef FU_DIV_SIGNED_EN
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
`else
        end else begin
            q = a / b;
            r = a % b;
        end
`endif
    endtask

    // Monitor: compare on finish, and require finish to last one cycle.
    always @(negedge clk) begin
        if (prev_finish) check("finish_pulse", {31'b0, bus.finish}, '0);
        prev_finish = bus.finish;
        if (bus.finish) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", {31'b0, bus.finish}, '0);
            end else begin
                mon_e = sb.pop_front();
                check("res", bus.res, mon_e.res);
                check("rem", bus.rem, mon_e.rem);
                check("latency", W'(cycle - mon_e.start), W'(fu_div_latency(W)));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("drain", W'(sb.size()), '0);
        sb.delete();
    endtask

    // Start one operation at a negedge; EN is sampled on the next posedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        model(a, b, e.res, e.rem);
        @(negedge clk);
        bus.EN = 1'b1;
        bus.A  = a;
        bus.B  = b;
        e.start = cycle;
        sb.push_back(e);
        @(negedge clk);
        bus.EN = 1'b0;
        check("busy_calc", {31'b0, bus.busy}, 32'd1);
        wait_drain();
        repeat (3) @(negedge clk);
        check("res_hold", bus.res, e.res);
        check("rem_hold", bus.rem, e.rem);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c0;
        rst    = 1'b1;
        bus.EN = 1'b0;
        bus.A  = '0;
        bus.B  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_res",    bus.res, '0);
        check("reset_rem",    bus.rem, '0);
        check("reset_finish", {31'b0, bus.finish}, '0);
        check("reset_busy",   {31'b0, bus.busy}, '0);

        // Directed cases
        run_op(32'd100, 32'd7);
        run_op(32'hFFFF_FFFF, 32'd1);
        run_op(32'd5, 32'd9);
        run_op(32'h0000_1234, 32'd0);

        // EN held high: accepted once every WIDTH+2 cycles, ignored while busy
        @(negedge clk);
        bus.EN = 1'b1;
        bus.A  = 32'd50;
        bus.B  = 32'd5;
        c0 = cycle;
        for (int k = 0; k < 3; k++) begin
            model(32'd50, 32'd5, e.res, e.rem);
            e.start = c0 + k * (W + 2);
            sb.push_back(e);
        end
        repeat (80) @(negedge clk);
        bus.EN = 1'b0;
        wait_drain();

        // Reset ten cycles into CALC aborts the op without a finish
        @(negedge clk);
        bus.EN = 1'b1;
        bus.A  = 32'd9999;
        bus.B  = 32'd3;
        @(negedge clk);
        bus.EN = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_res",  bus.res, '0);
        check("abort_rem",  bus.rem, '0);
        check("abort_busy", {31'b0, bus.busy}, '0);
        repeat (40) @(negedge clk);
        run_op(32'd9, 32'd4);

        // EN asserted in the same cycle as reset: reset wins
        @(negedge clk);
        rst    = 1'b1;
        bus.EN = 1'b1;
        bus.A  = 32'd77;
        bus.B  = 32'd7;
        @(negedge clk);
        rst    = 1'b0;
        bus.EN = 1'b0;
        check("rst_vs_en_busy", {31'b0, bus.busy}, '0);
        repeat (40) @(negedge clk);

        // Random operands, small and full-range divisors
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? W'($urandom_range(1, 300)) : W'($urandom);
            run_op(ra, rb);
        end

`ifdef FU_DIV_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2);
        run_op(32'h8000_0000, 32'hFFFF_FFFF);
        run_op(32'd100, 32'hFFFF_FFF9);
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_op(32'hFFFF_FFF9, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
